mul_seq: RTL

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/mera_alu_pkg.sv | 13 +
 rtl/mul_seq.sv | 117 +++++++++++
 2 files changed

// File: rtl/mera_alu_pkg.sv
// Shared constants for the cascaded 4-bit ALU slices and the multiplier FSM state type.
package mera_alu_pkg;

   localparam logic [3:0] ALU_S_ADD   = 4'b1001;
   localparam logic       ALU_M_ARITH = 1'b0;
   localparam logic       ALU_CN_NONE = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mul_state_e;

endpackage

// File: rtl/mul_seq.sv
// Sequential shift-add unsigned multiplier using externally instantiated 4-bit ALU slices.
// Optional macro MUL_OVF_EN enables the registered high-product-half overflow flag.
module mul_seq
   import mera_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic               clk_sys,
   input  logic               clr_,
   input  logic               start,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [WIDTH-1:0]   mplier,
   output logic [WIDTH-1:0]   alu_a,
   output logic [WIDTH-1:0]   alu_b,
   output logic [3:0]         alu_s,
   output logic               alu_m,
   output logic               alu_cn_,
   input  logic [WIDTH-1:0]   alu_f,
   input  logic               alu_cn4_,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] prod,
   output logic               ovf
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   mul_state_e         r_state;
   mul_state_e         w_state_nxt;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_mreg;
   logic [WIDTH-1:0]   r_mcand;
   logic [2*WIDTH-1:0] r_prod;
   logic               r_done;
   logic               w_load;
   logic               w_last;
   logic [2*WIDTH-1:0] w_step;

   always_ff @(posedge clk_sys or negedge clr_) begin
      if (!clr_) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (r_cnt == CW'(1)) begin
               w_last      = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Adder carry becomes the new accumulator MSB so the shifted sum loses nothing.
   always_comb begin
      if (r_mreg[0]) w_step = {~alu_cn4_, alu_f, r_mreg[WIDTH-1:1]};
      else           w_step = {1'b0, r_acc, r_mreg[WIDTH-1:1]};
   end

   always_ff @(posedge clk_sys or negedge clr_) begin
      if (!clr_) begin
         r_cnt   <= '0;
         r_acc   <= '0;
         r_mreg  <= '0;
         r_mcand <= '0;
         r_prod  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_load) begin
            r_mcand <= mcand;
            r_mreg  <= mplier;
            r_acc   <= '0;
            r_cnt   <= CW'(WIDTH);
         end else if (r_state == ST_RUN) begin
            {r_acc, r_mreg} <= w_step;
            r_cnt           <= r_cnt - CW'(1);
         end
         if (w_last) r_prod <= w_step;
      end
   end

`ifdef MUL_OVF_EN
   logic r_ovf;

   always_ff @(posedge clk_sys or negedge clr_) begin
      if (!clr_)       r_ovf <= 1'b0;
      else if (w_last) r_ovf <= |w_step[2*WIDTH-1:WIDTH];
   end

   assign ovf = r_ovf;
`else
   assign ovf = 1'b0;
`endif

   assign alu_a   = r_acc;
   assign alu_b   = r_mcand;
   assign alu_s   = ALU_S_ADD;
   assign alu_m   = ALU_M_ARITH;
   assign alu_cn_ = ALU_CN_NONE;
   assign busy    = (r_state == ST_RUN);
   assign done    = r_done;
   assign prod    = r_prod;

endmodule
